// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_pkg                                                             |
// | Shared state encodings and digit helpers for the HH:MM:SS set logic.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package clock_pkg;

  typedef enum logic [3:0] {
    ST_RUN     = 4'd0,
    ST_EDIT_SO = 4'd1,
    ST_EDIT_ST = 4'd2,
    ST_EDIT_MO = 4'd3,
    ST_EDIT_MT = 4'd4,
    ST_EDIT_HO = 4'd5,
    ST_EDIT_HT = 4'd6,
    ST_LOAD    = 4'd7
  } state_e;

  localparam logic [3:0] MAX_SO         = 4'd9;
  localparam logic [3:0] MAX_ST         = 4'd5;
  localparam logic [3:0] MAX_MO         = 4'd9;
  localparam logic [3:0] MAX_MT         = 4'd5;
  localparam logic [3:0] MAX_HO         = 4'd9;
  localparam logic [3:0] MAX_HO_CLAMPED = 4'd3;

  // Digit n (1=SO .. 6=HT) occupies bits [4n-1 : 4n-4] of the time word.
  function automatic logic [4:0] digit_lsb(input logic [3:0] n);
    logic [3:0] k;
    k = n - 4'd1;
    return {k[2:0], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cycle_timer                                                           |
// | Restartable cycle counter; done pulses on the last enabled count.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] terminal_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic             at_terminal;

  assign at_terminal = (count_q == terminal_i);
  assign done_o      = enable_i && !restart_i && at_terminal;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (restart_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= at_terminal ? '0 : count_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_set_controller                                                  |
// | Time-set sequencer: edits a shadow HH:MM:SS and commits with LOAD.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT  = 50_000_000,
  parameter int unsigned BLINK_HALF    = 12_500_000,
  parameter logic [3:0]  HOUR_TENS_MAX = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_pulse,
  input  logic        inc_pulse,
  input  logic [23:0] time_now,
  output logic [3:0]  state,
  output logic [23:0] time_load,
  output logic        edit_active,
  output logic        blink
);

  localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int unsigned BLNK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    (IDLE_TIMEOUT > 0) ? IDLE_W'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [BLNK_W-1:0] BLNK_LAST =
    (BLINK_HALF > 0) ? BLNK_W'(BLINK_HALF - 1) : '0;

  state_e      state_q, state_d;
  logic [23:0] shadow_q, shadow_d;
  logic        edit_q, edit_d;
  logic        blink_q, blink_d;

  logic        in_edit;
  logic        any_pulse;
  logic        timer_restart;
  logic        idle_done;
  logic        blink_done;

  assign in_edit       = (state_q != ST_RUN) && (state_q != ST_LOAD);
  assign any_pulse     = mode_pulse | inc_pulse;
  assign timer_restart = (in_edit && any_pulse) || ((state_q == ST_RUN) && mode_pulse);

  cycle_timer #(.WIDTH(IDLE_W)) u_idle_timer (
    .clk        (clk),
    .rst        (rst),
    .restart_i  (timer_restart),
    .enable_i   (in_edit && !any_pulse && (IDLE_TIMEOUT != 0)),
    .terminal_i (IDLE_LAST),
    .done_o     (idle_done)
  );

  cycle_timer #(.WIDTH(BLNK_W)) u_blink_timer (
    .clk        (clk),
    .rst        (rst),
    .restart_i  (timer_restart),
    .enable_i   (in_edit && !any_pulse),
    .terminal_i (BLNK_LAST),
    .done_o     (blink_done)
  );

  // Increment of the selected digit, including the hours-tens clamp of HO.
  logic [4:0]  sel_lsb;
  logic [3:0]  sel_cur;
  logic [3:0]  sel_max;
  logic [3:0]  sel_inc;
  logic [23:0] shadow_inc;

  always_comb begin
    sel_lsb    = digit_lsb(state_q);
    sel_cur    = shadow_q[sel_lsb +: 4];
    sel_max    = MAX_SO;
    unique case (state_q)
      ST_EDIT_ST: sel_max = MAX_ST;
      ST_EDIT_MO: sel_max = MAX_MO;
      ST_EDIT_MT: sel_max = MAX_MT;
      ST_EDIT_HO: sel_max = (shadow_q[23:20] == HOUR_TENS_MAX) ? MAX_HO_CLAMPED : MAX_HO;
      ST_EDIT_HT: sel_max = HOUR_TENS_MAX;
      default:    sel_max = MAX_SO;
    endcase
    sel_inc    = (sel_cur >= sel_max) ? 4'd0 : sel_cur + 4'd1;
    shadow_inc = shadow_q;
    shadow_inc[sel_lsb +: 4] = sel_inc;
    if ((state_q == ST_EDIT_HT) && (sel_inc == HOUR_TENS_MAX) &&
        (shadow_q[19:16] > MAX_HO_CLAMPED)) begin
      shadow_inc[19:16] = MAX_HO_CLAMPED;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    unique case (state_q)
      ST_RUN: begin
        if (mode_pulse) begin
          shadow_d = time_now;
          state_d  = ST_EDIT_HT;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      default: begin
        if (mode_pulse) begin
          state_d = (state_q == ST_EDIT_SO) ? ST_LOAD : state_e'(state_q - 4'd1);
        end else if (inc_pulse) begin
          shadow_d = shadow_inc;
        end else if (idle_done) begin
          state_d = ST_RUN;
        end
      end
    endcase

    edit_d = (state_d != ST_RUN) && (state_d != ST_LOAD);
    if (!edit_d || timer_restart) begin
      blink_d = 1'b0;
    end else if (blink_done) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      shadow_q <= '0;
      edit_q   <= 1'b0;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      edit_q   <= edit_d;
      blink_q  <= blink_d;
    end
  end

  assign state       = state_q;
  assign time_load   = shadow_q;
  assign edit_active = edit_q;
  assign blink       = blink_q;

endmodule
`default_nettype wire
